// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with prioritised redirects, stall-time redirect capture and an optional return-address stack.
// Define FETCH_PC_RAS_EN to compile in the return-address stack.
module fetch_pc_gen #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        INSN_BYTES   = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC     = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]  EXCEPTION_PC = ADDR_W'(32'h0000_2000),
  parameter int unsigned        RAS_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pc_write,
  input  logic                         exc_valid,
  input  logic                         br_valid,
  input  logic [ADDR_W-1:0]            br_target,
  input  logic                         jmp_valid,
  input  logic [ADDR_W-1:0]            jmp_target,
  input  logic                         jmp_is_call,
  input  logic [ADDR_W-1:0]            jmp_link,
  input  logic                         ret_valid,
  input  logic [ADDR_W-1:0]            ret_target,
  output logic [ADDR_W-1:0]            pc,
  output logic                         redirect_pending,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow
);

  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;

  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_JR   = 2'd1,
    PRIO_BR   = 2'd2,
    PRIO_EXC  = 2'd3
  } prio_t;

  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  prio_t             r_pend_prio;
  logic [ADDR_W-1:0] r_pend_tgt;

  logic              w_live_valid;
  prio_t             w_live_prio;
  logic [ADDR_W-1:0] w_live_tgt;
  logic              w_live_wins;
  logic              w_capture;
  logic              w_take_live;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_ret_tgt;

  always_comb begin
    w_live_valid = 1'b0;
    w_live_prio  = PRIO_NONE;
    w_live_tgt   = '0;
    if (exc_valid) begin
      w_live_valid = 1'b1;
      w_live_prio  = PRIO_EXC;
      w_live_tgt   = EXCEPTION_PC;
    end else if (br_valid) begin
      w_live_valid = 1'b1;
      w_live_prio  = PRIO_BR;
      w_live_tgt   = br_target;
    end else if (jmp_valid) begin
      w_live_valid = 1'b1;
      w_live_prio  = PRIO_JR;
      w_live_tgt   = jmp_target;
    end else if (ret_valid) begin
      w_live_valid = 1'b1;
      w_live_prio  = PRIO_JR;
      w_live_tgt   = w_ret_tgt;
    end
  end

  // A live redirect beats a pending one of equal priority, both when capturing and when applying.
  assign w_live_wins = w_live_valid && (!r_pend || (w_live_prio >= r_pend_prio));
  assign w_capture   = !pc_write && w_live_wins;
  assign w_take_live = pc_write && w_live_wins;

  always_comb begin
    w_next_pc = r_pc + ADDR_W'(INSN_BYTES);
    if (w_take_live)
      w_next_pc = w_live_tgt;
    else if (r_pend)
      w_next_pc = r_pend_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_prio <= PRIO_NONE;
      r_pend_tgt  <= '0;
    end else if (pc_write) begin
      r_pc   <= w_next_pc;
      r_pend <= 1'b0;
    end else if (w_capture) begin
      r_pend      <= 1'b1;
      r_pend_prio <= w_live_prio;
      r_pend_tgt  <= w_live_tgt;
    end
  end

  assign pc               = r_pc;
  assign redirect_pending = r_pend;

`ifdef FETCH_PC_RAS_EN
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_pend_call;
  logic              r_pend_ret;
  logic [ADDR_W-1:0] r_pend_link;

  logic              w_live_call;
  logic              w_live_ret;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_push_link;
  logic              w_ras_full;

  assign w_ras_full = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_ret_tgt  = (r_cnt != '0) ? r_ras[r_sp - SP_W'(1)] : ret_target;

  always_comb begin
    w_live_call = 1'b0;
    w_live_ret  = 1'b0;
    if (!exc_valid && !br_valid) begin
      if (jmp_valid)
        w_live_call = jmp_is_call;
      else if (ret_valid)
        w_live_ret = 1'b1;
    end
  end

  // Stack effects follow whichever redirect actually lands on pc; the loser leaves the stack alone.
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_link = r_pend_link;
    if (w_take_live) begin
      w_push      = w_live_call;
      w_pop       = w_live_ret && (r_cnt != '0);
      w_push_link = jmp_link;
    end else if (pc_write && r_pend) begin
      w_push = r_pend_call;
      w_pop  = r_pend_ret && (r_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_push) begin
      r_sp <= r_sp + SP_W'(1);
      if (w_ras_full)
        r_ovf <= 1'b1;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_pop) begin
      r_sp  <= r_sp - SP_W'(1);
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_ras[r_sp] <= w_push_link;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_call <= 1'b0;
      r_pend_ret  <= 1'b0;
      r_pend_link <= '0;
    end else if (w_capture) begin
      r_pend_call <= w_live_call;
      r_pend_ret  <= w_live_ret;
      r_pend_link <= jmp_link;
    end
  end

  assign ras_count    = r_cnt;
  assign ras_overflow = r_ovf;
`else
  logic w_unused;

  assign w_ret_tgt    = ret_target;
  assign w_unused     = ^{jmp_is_call, jmp_link};
  assign ras_count    = '0;
  assign ras_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset, pc_write, exc_valid, br_valid, jmp_valid, jmp_is_call, ret_valid;
  logic [31:0] br_target, jmp_target, jmp_link, ret_target;
  logic [31:0] pc;
  logic        redirect_pending;
  logic [3:0]  ras_count;
  logic        ras_overflow;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [3:0]  cnt;
    logic        ovf;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  e_cnt = '0;
  logic        e_ovf = 1'b0;

  fetch_pc_gen dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .exc_valid(exc_valid),
    .br_valid(br_valid), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .jmp_is_call(jmp_is_call), .jmp_link(jmp_link),
    .ret_valid(ret_valid), .ret_target(ret_target),
    .pc(pc), .redirect_pending(redirect_pending),
    .ras_count(ras_count), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pc",   pc,                      e.pc);
      chk(e.nm, "pend", {31'd0, redirect_pending}, {31'd0, e.pend});
      chk(e.nm, "cnt",  {28'd0, ras_count},       {28'd0, e.cnt});
      chk(e.nm, "ovf",  {31'd0, ras_overflow},    {31'd0, e.ovf});
    end
  end

  task automatic clr();
    exc_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; jmp_is_call = 1'b0; ret_valid = 1'b0;
    br_target = '0; jmp_target = '0; jmp_link = '0; ret_target = '0;
  endtask

  task automatic tick(input logic [31:0] epc, input logic epend, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.pc = epc; e.pend = epend; e.cnt = e_cnt; e.ovf = e_ovf; e.nm = nm;
    q.push_back(e);
    clr();
  endtask

  task automatic jmp(input logic [31:0] t);
    jmp_valid = 1'b1; jmp_target = t;
  endtask

  task automatic br(input logic [31:0] t);
    br_valid = 1'b1; br_target = t;
  endtask

  task automatic call(input logic [31:0] t, input logic [31:0] l);
    jmp_valid = 1'b1; jmp_target = t; jmp_is_call = 1'b1; jmp_link = l;
  endtask

  task automatic ret(input logic [31:0] t);
    ret_valid = 1'b1; ret_target = t;
  endtask

  initial begin
    clr();
    reset = 1'b1; pc_write = 1'b1;
    br(32'h400);
    tick(32'h0, 1'b0, "reset");
    reset = 1'b0;
    tick(32'h4, 1'b0, "seq1");
    tick(32'h8, 1'b0, "seq2");
    tick(32'hC, 1'b0, "seq3");

    jmp(32'hFFFF_FFFC); tick(32'hFFFF_FFFC, 1'b0, "to_top");
    tick(32'h0, 1'b0, "wrap");

    jmp(32'h100);       tick(32'h100, 1'b0, "jmp100");
    pc_write = 1'b0;    tick(32'h100, 1'b0, "stall_hold");
    br(32'h400);        tick(32'h100, 1'b1, "stall_br");
    jmp(32'h800);       tick(32'h100, 1'b1, "stall_jmp_lower");
    pc_write = 1'b1;    tick(32'h400, 1'b0, "release_br");
    tick(32'h404, 1'b0, "after_release");

    pc_write = 1'b0;
    jmp(32'h800);       tick(32'h404, 1'b1, "stall_jmp");
    exc_valid = 1'b1;   tick(32'h404, 1'b1, "stall_exc");
    pc_write = 1'b1;    tick(32'h2000, 1'b0, "release_exc");
    tick(32'h2004, 1'b0, "after_exc");

    pc_write = 1'b0;
    br(32'h600);        tick(32'h2004, 1'b1, "tie_first");
    br(32'h700);        tick(32'h2004, 1'b1, "tie_second");
    pc_write = 1'b1;    tick(32'h700, 1'b0, "tie_replaced");

    pc_write = 1'b0;
    br(32'h900);        tick(32'h700, 1'b1, "pend_br");
    pc_write = 1'b1; jmp(32'hA00); tick(32'h900, 1'b0, "pend_beats_live");
    pc_write = 1'b0;
    jmp(32'hB00);       tick(32'h900, 1'b1, "pend_jmp");
    pc_write = 1'b1; br(32'hC00);  tick(32'hC00, 1'b0, "live_beats_pend");
    pc_write = 1'b0;
    jmp(32'hD00);       tick(32'hC00, 1'b1, "pend_jmp_tie");
    pc_write = 1'b1; jmp(32'hE00); tick(32'hE00, 1'b0, "live_wins_tie");

    jmp(32'h1000); ret(32'h3000); tick(32'h1000, 1'b0, "jmp_over_ret");

`ifdef FETCH_PC_RAS_EN
    call(32'h500, 32'h104); e_cnt = 4'd1; tick(32'h500, 1'b0, "call");
    ret(32'h0);             e_cnt = 4'd0; tick(32'h104, 1'b0, "ret_pop");

    for (int k = 1; k <= 9; k++) begin
      call(32'h5000, 32'(k * 16));
      e_cnt = (k > 8) ? 4'd8 : 4'(k);
      if (k == 9) e_ovf = 1'b1;
      tick(32'h5000, 1'b0, "call_n");
    end
    for (int k = 9; k >= 2; k--) begin
      ret(32'h7000);
      e_cnt = 4'(k - 2);
      tick(32'(k * 16), 1'b0, "ret_n");
    end
    ret(32'h7000);          tick(32'h7000, 1'b0, "ret_empty");

    call(32'h600, 32'h44);  e_cnt = 4'd1; tick(32'h600, 1'b0, "call_44");
    pc_write = 1'b0;
    ret(32'h9000);          tick(32'h600, 1'b1, "stall_ret");
    pc_write = 1'b1;        e_cnt = 4'd0; tick(32'h44, 1'b0, "release_ret");

    pc_write = 1'b0;
    call(32'h700, 32'h55);  tick(32'h44, 1'b1, "stall_call");
    exc_valid = 1'b1;       tick(32'h44, 1'b1, "stall_call_exc");
    pc_write = 1'b1;        tick(32'h2000, 1'b0, "call_discarded");
`else
    call(32'h500, 32'h104); tick(32'h500, 1'b0, "call_plain");
    ret(32'h0);             tick(32'h0, 1'b0, "ret_plain");
    ret(32'h3000);          tick(32'h3000, 1'b0, "ret_target");
`endif

    pc_write = 1'b0;
    br(32'h123);            tick(pc_snap(), 1'b1, "stall_before_reset");
    reset = 1'b1;           e_cnt = '0; e_ovf = 1'b0; tick(32'h0, 1'b0, "reset_mid_stall");
    reset = 1'b0; pc_write = 1'b1; tick(32'h4, 1'b0, "after_reset");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // pc expected just before the final stall sequence, fixed by the build variant above.
  function automatic logic [31:0] pc_snap();
`ifdef FETCH_PC_RAS_EN
    return 32'h2000;
`else
    return 32'h3000;
`endif
  endfunction

endmodule
